// File: rtl/tl_ul_responder.sv
// tl_ul_responder: single-beat TileLink-UL device backed by a 64-bit-wide local
// memory. One request in flight at a time. The response appears RESP_LATENCY
// cycles after A-fire. Out-of-window, oversize, misaligned and unsupported
// requests are denied, and each denial is counted.
//
// Ports:
//   clock, reset          sole clock; synchronous active-high reset
//   a_*                   A channel (request) from the tile
//   d_*                   D channel (response) to the tile
//   busy                  a request is in flight (not IDLE)
//   err_count             saturating count of denied requests
module tl_ul_responder #(
  parameter logic [31:0] BASE_ADDR    = 32'h6000_0000,
  parameter int          DEPTH_LOG2   = 8,
  parameter int          RESP_LATENCY = 2
) (
  input  logic        clock,
  input  logic        reset,
  output logic        a_ready,
  input  logic        a_valid,
  input  logic [2:0]  a_bits_opcode,
  input  logic [2:0]  a_bits_param,
  input  logic [3:0]  a_bits_size,
  input  logic [1:0]  a_bits_source,
  input  logic [31:0] a_bits_address,
  input  logic [7:0]  a_bits_mask,
  input  logic [63:0] a_bits_data,
  input  logic        d_ready,
  output logic        d_valid,
  output logic [2:0]  d_bits_opcode,
  output logic [1:0]  d_bits_param,
  output logic [3:0]  d_bits_size,
  output logic [1:0]  d_bits_source,
  output logic [1:0]  d_bits_sink,
  output logic        d_bits_denied,
  output logic [63:0] d_bits_data,
  output logic        d_bits_corrupt,
  output logic        busy,
  output logic [15:0] err_count
);

  localparam int          DEPTH     = 1 << DEPTH_LOG2;
  localparam int          NUM_LANES = 8;
  localparam logic [32:0] WIN_BYTES = 33'(DEPTH) << 3;
  // WAIT is skipped entirely when the latency is 1, so the load value only
  // matters for latencies of 2 and up.
  localparam logic [3:0]  LAT_LOAD  = (RESP_LATENCY > 1) ? 4'(RESP_LATENCY - 2) : 4'd0;

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

  typedef struct packed {
    logic [2:0]  opcode;
    logic [3:0]  size;
    logic [1:0]  source;
    logic        denied;
    logic        corrupt;
    logic [63:0] data;
  } resp_t;

  state_t state, state_nxt;
  logic [3:0] lat_cnt;
  resp_t      rsp, rsp_nxt;

  logic [63:0] mem [DEPTH];

  // ---------------- request decode ----------------
  logic [31:0]           off;
  logic                  in_range, misalign, is_put, is_get, denied;
  logic [DEPTH_LOG2-1:0] idx;
  logic                  a_fire, wr_en;
  logic                  unused_bits;

  assign off      = a_bits_address - BASE_ADDR;
  // Offset is compared in 33 bits so a window ending at 2^32 still works.
  assign in_range = (a_bits_address >= BASE_ADDR) && ({1'b0, off} < WIN_BYTES);
  assign is_put   = (a_bits_opcode == 3'd0) || (a_bits_opcode == 3'd1);
  assign is_get   = (a_bits_opcode == 3'd4);
  assign idx      = off[DEPTH_LOG2+2:3];

  always_comb begin
    misalign = 1'b0;
    case (a_bits_size)
      4'd1:    misalign = a_bits_address[0];
      4'd2:    misalign = |a_bits_address[1:0];
      4'd3:    misalign = |a_bits_address[2:0];
      default: misalign = 1'b0;
    endcase
  end

  assign denied  = !in_range || (a_bits_size > 4'd3) || misalign || !(is_put || is_get);
  // a_ready is gated by reset directly so it reads 0 throughout reset,
  // whatever the state register held beforehand.
  assign a_ready = (state == S_IDLE) && !reset;
  assign a_fire  = a_valid && a_ready;
  assign wr_en   = a_fire && is_put && !denied;

  assign unused_bits = ^{a_bits_param, off[2:0]};

  // ---------------- memory (not reset) ----------------
  always_ff @(posedge clock) begin
    if (wr_en) begin
      for (int b = 0; b < NUM_LANES; b++)
        if (a_bits_mask[b]) mem[idx][8*b +: 8] <= a_bits_data[8*b +: 8];
    end
  end

  // ---------------- FSM ----------------
  always_ff @(posedge clock) begin
    if (reset) begin
      state   <= S_IDLE;
      lat_cnt <= '0;
    end else begin
      state <= state_nxt;
      if (a_fire)
        lat_cnt <= LAT_LOAD;
      else if (state == S_WAIT && lat_cnt != 4'd0)
        lat_cnt <= lat_cnt - 4'd1;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: if (a_fire) state_nxt = (RESP_LATENCY > 1) ? S_WAIT : S_RESP;
      S_WAIT: if (lat_cnt == 4'd0) state_nxt = S_RESP;
      S_RESP: if (d_ready) state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // ---------------- response capture ----------------
  // Everything the response needs is captured at A-fire, including read data,
  // so the payload is stable for the whole of RESP regardless of later writes.
  always_comb begin
    rsp_nxt         = '0;
    rsp_nxt.opcode  = is_get ? 3'd1 : 3'd0;
    rsp_nxt.size    = a_bits_size;
    rsp_nxt.source  = a_bits_source;
    rsp_nxt.denied  = denied;
    rsp_nxt.corrupt = is_get && denied;
    rsp_nxt.data    = (is_get && !denied) ? mem[idx] : 64'd0;
  end

  always_ff @(posedge clock) begin
    if (reset)       rsp <= '0;
    else if (a_fire) rsp <= rsp_nxt;
  end

  always_ff @(posedge clock) begin
    if (reset)
      err_count <= '0;
    else if (a_fire && denied && err_count != 16'hFFFF)
      err_count <= err_count + 16'd1;
  end

  assign d_valid        = (state == S_RESP);
  assign busy           = (state != S_IDLE);
  assign d_bits_opcode  = rsp.opcode;
  assign d_bits_param   = 2'd0;
  assign d_bits_size    = rsp.size;
  assign d_bits_source  = rsp.source;
  assign d_bits_sink    = 2'd0;
  assign d_bits_denied  = rsp.denied;
  assign d_bits_data    = rsp.data;
  assign d_bits_corrupt = rsp.corrupt;

endmodule

// File: tb/tb_tl_ul_responder.sv
// Directed bench for tl_ul_responder: a latency-2 instance carries most of
// the sequence, a latency-1 instance checks back-to-back throughput.
module tb_tl_ul_responder;
  logic clock = 1'b0;
  logic reset;
  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;

  // latency-2 instance
  logic        a_ready, a_valid, d_ready, d_valid, d_denied, d_corrupt, busy;
  logic [2:0]  a_op, a_param, d_op;
  logic [3:0]  a_size, d_size;
  logic [1:0]  a_src, d_param, d_src, d_sink;
  logic [31:0] a_addr;
  logic [7:0]  a_mask;
  logic [63:0] a_data, d_data;
  logic [15:0] err_count;

  // latency-1 instance
  logic        a_ready1, a_valid1, d_ready1, d_valid1, d_denied1, d_corrupt1, busy1;
  logic [2:0]  a_op1, d_op1;
  logic [3:0]  d_size1;
  logic [1:0]  a_src1, d_param1, d_src1, d_sink1;
  logic [31:0] a_addr1;
  logic [63:0] d_data1;
  logic [15:0] err_count1;

  tl_ul_responder #(.RESP_LATENCY(2)) dut (
    .clock(clock), .reset(reset), .a_ready(a_ready), .a_valid(a_valid),
    .a_bits_opcode(a_op), .a_bits_param(a_param), .a_bits_size(a_size),
    .a_bits_source(a_src), .a_bits_address(a_addr), .a_bits_mask(a_mask),
    .a_bits_data(a_data), .d_ready(d_ready), .d_valid(d_valid),
    .d_bits_opcode(d_op), .d_bits_param(d_param), .d_bits_size(d_size),
    .d_bits_source(d_src), .d_bits_sink(d_sink), .d_bits_denied(d_denied),
    .d_bits_data(d_data), .d_bits_corrupt(d_corrupt), .busy(busy),
    .err_count(err_count));

  tl_ul_responder #(.RESP_LATENCY(1)) dut1 (
    .clock(clock), .reset(reset), .a_ready(a_ready1), .a_valid(a_valid1),
    .a_bits_opcode(a_op1), .a_bits_param(3'd0), .a_bits_size(4'd3),
    .a_bits_source(a_src1), .a_bits_address(a_addr1), .a_bits_mask(8'hFF),
    .a_bits_data(64'd0), .d_ready(d_ready1), .d_valid(d_valid1),
    .d_bits_opcode(d_op1), .d_bits_param(d_param1), .d_bits_size(d_size1),
    .d_bits_source(d_src1), .d_bits_sink(d_sink1), .d_bits_denied(d_denied1),
    .d_bits_data(d_data1), .d_bits_corrupt(d_corrupt1), .busy(busy1),
    .err_count(err_count1));

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Called at a negedge with the DUT idle; returns at a negedge, idle again.
  // d_ready is held at 1 so D-fire happens in the first RESP cycle.
  task automatic txn(input string tag, input logic [2:0] op, input logic [3:0] sz,
                     input logic [1:0] src, input logic [31:0] addr,
                     input logic [7:0] mask, input logic [63:0] data,
                     input logic [2:0] eop, input logic eden, input logic [63:0] edata);
    chk({tag, ".a_ready"}, 64'(a_ready), 64'd1);
    a_valid = 1'b1; a_op = op; a_size = sz; a_src = src;
    a_addr = addr; a_mask = mask; a_data = data;
    @(posedge clock); #1 a_valid = 1'b0;
    @(negedge clock);
    chk({tag, ".dv_early"}, 64'(d_valid), 64'd0);
    chk({tag, ".busy"}, 64'(busy), 64'd1);
    @(negedge clock);
    chk({tag, ".dv"}, 64'(d_valid), 64'd1);
    chk({tag, ".op"}, 64'(d_op), 64'(eop));
    chk({tag, ".src"}, 64'(d_src), 64'(src));
    chk({tag, ".size"}, 64'(d_size), 64'(sz));
    chk({tag, ".den"}, 64'(d_denied), 64'(eden));
    chk({tag, ".corrupt"}, 64'(d_corrupt), 64'(eden && eop == 3'd1));
    chk({tag, ".data"}, d_data, edata);
    @(negedge clock);
    chk({tag, ".dv_after"}, 64'(d_valid), 64'd0);
  endtask

  logic [63:0] held;
  int          prev_fire;

  initial begin
    reset = 1'b1; a_valid = 1'b0; d_ready = 1'b1; a_op = '0; a_param = '0;
    a_size = '0; a_src = '0; a_addr = '0; a_mask = '0; a_data = '0;
    a_valid1 = 1'b0; d_ready1 = 1'b1; a_op1 = 3'd4; a_src1 = '0; a_addr1 = 32'h6000_0000;
    prev_fire = 0;

    repeat (2) @(negedge clock);
    chk("rst.a_ready", 64'(a_ready), 64'd0);
    chk("rst.d_valid", 64'(d_valid), 64'd0);
    chk("rst.busy", 64'(busy), 64'd0);
    chk("rst.err", 64'(err_count), 64'd0);
    chk("rst.d_data", d_data, 64'd0);
    reset = 1'b0;
    @(negedge clock);
    chk("post_rst.a_ready", 64'(a_ready), 64'd1);

    // write / read back, partial write
    txn("put_full", 3'd0, 4'd3, 2'd1, 32'h6000_0010, 8'hFF, 64'h1122334455667788, 3'd0, 1'b0, 64'd0);
    txn("get1", 3'd4, 4'd3, 2'd2, 32'h6000_0010, 8'hFF, 64'd0, 3'd1, 1'b0, 64'h1122334455667788);
    txn("put_part", 3'd1, 4'd3, 2'd3, 32'h6000_0010, 8'h0F, 64'hAAAAAAAA_BBBBBBBB, 3'd0, 1'b0, 64'd0);
    txn("get2", 3'd4, 4'd3, 2'd0, 32'h6000_0010, 8'h01, 64'd0, 3'd1, 1'b0, 64'h11223344_BBBBBBBB);
    // last word of the window
    txn("put_last", 3'd0, 4'd3, 2'd1, 32'h6000_07F8, 8'hFF, 64'hCAFEF00D_DEADBEEF, 3'd0, 1'b0, 64'd0);
    txn("get_last", 3'd4, 4'd3, 2'd1, 32'h6000_07F8, 8'hFF, 64'd0, 3'd1, 1'b0, 64'hCAFEF00D_DEADBEEF);

    // denials
    txn("get_oob", 3'd4, 4'd3, 2'd2, 32'h6000_0800, 8'hFF, 64'd0, 3'd1, 1'b1, 64'd0);
    txn("get_mis", 3'd4, 4'd2, 2'd3, 32'h6000_0002, 8'hFF, 64'd0, 3'd1, 1'b1, 64'd0);
    txn("op6", 3'd6, 4'd3, 2'd0, 32'h6000_0010, 8'hFF, 64'hFFFF_FFFF_FFFF_FFFF, 3'd0, 1'b1, 64'd0);
    chk("err3", 64'(err_count), 64'd3);
    txn("get_unch", 3'd4, 4'd3, 2'd1, 32'h6000_0010, 8'hFF, 64'd0, 3'd1, 1'b0, 64'h11223344_BBBBBBBB);
    txn("put_below", 3'd0, 4'd3, 2'd2, 32'h5FFF_FFF8, 8'hFF, 64'd5, 3'd0, 1'b1, 64'd0);
    chk("err4", 64'(err_count), 64'd4);

    // stall with d_ready low for 10 cycles
    d_ready = 1'b0;
    a_valid = 1'b1; a_op = 3'd4; a_size = 4'd3; a_src = 2'd2; a_addr = 32'h6000_07F8;
    @(posedge clock); #1 a_valid = 1'b0;
    repeat (2) @(negedge clock);
    held = d_data;
    chk("stall.dv0", 64'(d_valid), 64'd1);
    chk("stall.data0", held, 64'hCAFEF00D_DEADBEEF);
    for (int i = 0; i < 10; i++) begin
      @(negedge clock);
      chk("stall.dv", 64'(d_valid), 64'd1);
      chk("stall.data", d_data, held);
      chk("stall.src", 64'(d_src), 64'd2);
      chk("stall.a_ready", 64'(a_ready), 64'd0);
    end
    d_ready = 1'b1;
    @(negedge clock);
    chk("stall.dv_after", 64'(d_valid), 64'd0);
    chk("stall.a_ready_after", 64'(a_ready), 64'd1);

    // reset pulse while in WAIT
    a_valid = 1'b1; a_op = 3'd4; a_src = 2'd1; a_addr = 32'h6000_0010;
    @(posedge clock); #1 a_valid = 1'b0;
    @(negedge clock);
    chk("wrst.busy", 64'(busy), 64'd1);
    reset = 1'b1;
    @(negedge clock);
    chk("wrst.a_ready_in_rst", 64'(a_ready), 64'd0);
    reset = 1'b0;
    for (int i = 0; i < 4; i++) begin
      chk("wrst.dv", 64'(d_valid), 64'd0);
      @(negedge clock);
    end
    chk("wrst.err", 64'(err_count), 64'd0);
    chk("wrst.a_ready", 64'(a_ready), 64'd1);
    txn("get_after_rst", 3'd4, 4'd3, 2'd3, 32'h6000_0010, 8'hFF, 64'd0, 3'd1, 1'b0, 64'h11223344_BBBBBBBB);

    // latency-1: four back-to-back Gets, D-fires two cycles apart
    for (int k = 0; k < 4; k++) begin
      chk("l1.a_ready", 64'(a_ready1), 64'd1);
      a_valid1 = 1'b1; a_src1 = 2'(k); a_addr1 = 32'h6000_0000 + 32'(8 * k);
      @(posedge clock); #1;
      @(negedge clock);
      chk("l1.dv", 64'(d_valid1), 64'd1);
      chk("l1.src", 64'(d_src1), 64'(k));
      chk("l1.op", 64'(d_op1), 64'd1);
      chk("l1.a_ready_resp", 64'(a_ready1), 64'd0);
      if (k > 0) chk("l1.spacing", 64'(cyc - prev_fire), 64'd2);
      prev_fire = cyc;
      @(negedge clock);
    end
    a_valid1 = 1'b0;
    @(negedge clock);
    chk("l1.idle", 64'(busy1), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end
endmodule
